// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants for the instruction fetch stage
package fetch_unit_pkg;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          PC_STEP          = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order queue with synchronous clear and registered occupancy count
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push && !clear) mem[wr_ptr] <= din;
   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues credit-limited imem requests and queues
// returned words with their PCs for decode; redirect flushes and drops stale data
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                 N_param  = 32,
   parameter logic [N_param-1:0] RESET_PC = N_param'(RESET_PC_DEFAULT),
   parameter int                 FQ_DEPTH = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   output logic               imem_req_o,
   output logic [N_param-1:0] imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [N_param-1:0] imem_rdata_i,
   input  logic               redirect_i,
   input  logic [N_param-1:0] redirect_pc_i,
   output logic [N_param-1:0] instruction_o,
   output logic [N_param-1:0] pc_o,
   output logic               valid_o,
   input  logic               ready_i
);
   localparam int                 CW      = $clog2(FQ_DEPTH) + 1;
   localparam logic [CW:0]        DEPTH_X = (CW+1)'(FQ_DEPTH);
   localparam logic [N_param-1:0] STEP    = N_param'(PC_STEP);
   logic [N_param-1:0]   fetch_pc, resp_pc, redir_pc;
   logic [CW-1:0]        inflight, discard, live, count;
   logic [2*N_param-1:0] head;
   logic                 empty, req, fire, push, pop;
   assign redir_pc = {redirect_pc_i[N_param-1:2], 2'b00};
   // Credits cover queued entries plus live responses, so a push always has room
   always_comb begin
      live          = inflight - discard;
      req           = i_en && !redirect_i && (({1'b0, count} + {1'b0, live}) < DEPTH_X)
                      && ({1'b0, inflight} < DEPTH_X);
      fire          = req && imem_gnt_i;
      push          = imem_rvalid_i && (discard == '0) && !redirect_i;
      valid_o       = !empty && !redirect_i;
      pop           = valid_o && ready_i;
      instruction_o = valid_o ? head[N_param-1:0] : N_param'(INST_NOP);
      pc_o          = valid_o ? head[2*N_param-1:N_param] : '0;
   end
   assign imem_req_o  = req && !i_rst;
   assign imem_addr_o = fetch_pc;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
      end else if (redirect_i) begin
         fetch_pc <= redir_pc;
         resp_pc  <= redir_pc;
         inflight <= inflight - CW'(imem_rvalid_i);
         discard  <= inflight - CW'(imem_rvalid_i);
      end else begin
         if (fire) fetch_pc <= fetch_pc + STEP;
         inflight <= inflight + CW'(fire) - CW'(imem_rvalid_i);
         if (imem_rvalid_i && discard != '0) discard <= discard - CW'(1);
         if (push) resp_pc <= resp_pc + STEP;
      end
   fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH(2*N_param)) u_fifo (
      .clk(i_clk),
      .rst(i_rst),
      .push(push),
      .pop(pop),
      .clear(redirect_i),
      .din({resp_pc, imem_rdata_i}),
      .head(head),
      .count(count),
      .empty(empty)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, backpressure, redirect, async reset and PC wrap
module tb_fetch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, en, gnt, rvalid, redirect, ready, req, valid;
   logic [31:0] rdata, rpc, addr, instr, pc;
   logic w_rst, w_en, w_gnt, w_rvalid, w_redirect, w_ready, w_req, w_valid;
   logic [31:0] w_rdata, w_rpc, w_addr, w_instr, w_pc;
   int checks = 0;
   int errors = 0;
   fetch_unit #(.N_param(32), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en),
      .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .redirect_i(redirect), .redirect_pc_i(rpc),
      .instruction_o(instr), .pc_o(pc), .valid_o(valid), .ready_i(ready)
   );
   fetch_unit #(.N_param(32), .RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(4)) wdut (
      .i_clk(clk), .i_rst(w_rst), .i_en(w_en),
      .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
      .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
      .redirect_i(w_redirect), .redirect_pc_i(w_rpc),
      .instruction_o(w_instr), .pc_o(w_pc), .valid_o(w_valid), .ready_i(w_ready)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1; en = 0; gnt = 0; rvalid = 0; rdata = 0; redirect = 0; rpc = 0; ready = 0;
      w_rst = 1; w_en = 0; w_gnt = 0; w_rvalid = 0; w_rdata = 0; w_redirect = 0; w_rpc = 0; w_ready = 1;
      #3;
      chk("rst_req", req, 0);
      chk("rst_valid", valid, 0);
      chk("rst_instr", instr, 32'h13);
      chk("rst_pc", pc, 0);
      #9;
      rst = 0; w_rst = 0;
      // straight-line fetch, 1-cycle memory
      en = 1; ready = 1;
      for (int i = 0; i < 6; i++) begin
         gnt = (i < 4); rvalid = (i >= 1 && i <= 4); rdata = 32'hA0 + 32'(i) - 32'd1;
         #1;
         if (i < 4) begin
            chk("t1_req", req, 1);
            chk("t1_addr", addr, 32'(4*i));
         end
         if (i == 1) chk("t1_latency", valid, 0);
         if (i >= 2) begin
            chk("t1_valid", valid, 1);
            chk("t1_pc", pc, 32'(4*(i-2)));
            chk("t1_instr", instr, 32'hA0 + 32'(i-2));
         end
         cyc;
      end
      rvalid = 0; ready = 0; gnt = 1;
      #1;
      chk("t1_empty_valid", valid, 0);
      chk("t1_empty_instr", instr, 32'h13);
      chk("t1_empty_pc", pc, 0);
      chk("t1_next_addr", addr, 32'h10);
      // backpressure: four credits then request stops
      for (int k = 0; k < 6; k++) begin
         rvalid = (k >= 1 && k <= 4); rdata = 32'hB0 + 32'(k) - 32'd1;
         if (k > 0) #1;
         chk("t2_req", req, (k < 4));
         if (k < 4) chk("t2_addr", addr, 32'h10 + 32'(4*k));
         cyc;
      end
      rvalid = 0; gnt = 0;
      #1;
      chk("t2_full_pc", pc, 32'h10);
      chk("t2_full_req", req, 0);
      cyc;
      #1;
      chk("t2_hold_pc", pc, 32'h10);
      chk("t2_hold_instr", instr, 32'hB0);
      ready = 1;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk("t2_pop_pc", pc, 32'h10 + 32'(4*j));
         chk("t2_pop_instr", instr, 32'hB0 + 32'(j));
         chk("t2_pop_req", req, (j > 0));
         if (j == 1) chk("t2_resume_addr", addr, 32'h20);
         cyc;
      end
      // redirect with two requests in flight
      gnt = 1;
      #1;
      chk("t3_drained", valid, 0);
      chk("t3_addr0", addr, 32'h20);
      cyc;
      #1;
      chk("t3_addr1", addr, 32'h24);
      cyc;
      gnt = 0; redirect = 1; rpc = 32'h103;
      #1;
      chk("t3_redir_req", req, 0);
      cyc;
      redirect = 0; rvalid = 1; rdata = 32'hDEAD;
      #1;
      chk("t3_new_addr", addr, 32'h100);
      chk("t3_new_req", req, 1);
      cyc;
      rdata = 32'hBEEF; gnt = 1;
      #1;
      chk("t3_drop1", valid, 0);
      cyc;
      gnt = 0; rdata = 32'hC100;
      #1;
      chk("t3_drop2", valid, 0);
      chk("t3_addr_next", addr, 32'h104);
      cyc;
      rvalid = 0; ready = 0; gnt = 1;
      #1;
      chk("t3_first_pc", pc, 32'h100);
      chk("t3_first_instr", instr, 32'hC100);
      cyc;
      // redirect coinciding with a response, queue non-empty, ready high
      rvalid = 1; rdata = 32'hC104;
      #1;
      chk("t4_addr108", addr, 32'h108);
      cyc;
      rvalid = 0;
      #1;
      chk("t4_addr10c", addr, 32'h10C);
      cyc;
      redirect = 1; rpc = 32'h200; rvalid = 1; rdata = 32'hBAD; ready = 1;
      #1;
      chk("t4_redir_valid", valid, 0);
      chk("t4_redir_req", req, 0);
      cyc;
      redirect = 0; gnt = 0; rdata = 32'hBAD2;
      #1;
      chk("t4_cleared", valid, 0);
      chk("t4_addr200", addr, 32'h200);
      cyc;
      rvalid = 0; gnt = 1;
      #1;
      chk("t4_stale_dropped", valid, 0);
      cyc;
      gnt = 0; rvalid = 1; rdata = 32'hD200;
      #1;
      chk("t4_addr204", addr, 32'h204);
      cyc;
      rvalid = 0;
      #1;
      chk("t4_pc", pc, 32'h200);
      chk("t4_instr", instr, 32'hD200);
      cyc;
      // asynchronous reset with three entries queued
      ready = 0; gnt = 1;
      #1;
      cyc;
      rvalid = 1; rdata = 32'hE0;
      #1;
      cyc;
      rdata = 32'hE1;
      #1;
      cyc;
      gnt = 0; rdata = 32'hE2;
      #1;
      cyc;
      rvalid = 0;
      #1;
      chk("t5_pre_pc", pc, 32'h204);
      #2;
      rst = 1;
      #1;
      chk("t5_valid", valid, 0);
      chk("t5_instr", instr, 32'h13);
      chk("t5_req", req, 0);
      chk("t5_pc", pc, 0);
      cyc;
      rst = 0;
      #1;
      chk("t5_restart_req", req, 1);
      chk("t5_restart_addr", addr, 32'h0);
      cyc;
      gnt = 1;
      #1;
      cyc;
      gnt = 0; rvalid = 1; rdata = 32'hF0;
      #1;
      cyc;
      rvalid = 0;
      #1;
      chk("t5_out_pc", pc, 32'h0);
      chk("t5_out_instr", instr, 32'hF0);
      cyc;
      // PC wrap on the second instance
      w_en = 1; w_gnt = 1;
      #1;
      chk("t6_addr0", w_addr, 32'hFFFF_FFFC);
      cyc;
      w_rvalid = 1; w_rdata = 32'h11;
      #1;
      chk("t6_addr1", w_addr, 32'h0);
      cyc;
      w_gnt = 0; w_rdata = 32'h22;
      #1;
      chk("t6_pc0", w_pc, 32'hFFFF_FFFC);
      chk("t6_instr0", w_instr, 32'h11);
      cyc;
      w_rvalid = 0;
      #1;
      chk("t6_pc1", w_pc, 32'h0);
      chk("t6_instr1", w_instr, 32'h22);
      cyc;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
